// File: rtl/dds_ctrl_pkg.sv
// Shared constants and types for the DDS bank configuration sequencer.
package dds_ctrl_pkg;

   localparam logic [3:0] REG_FREQUENCY = 4'd0;
   localparam logic [3:0] REG_PHASE     = 4'd1;
   localparam logic [3:0] REG_SKEW      = 4'd2;
   localparam logic [3:0] REG_AMPLITUDE = 4'd3;
   localparam logic [3:0] REG_OFFSET    = 4'd4;
   localparam logic [3:0] REG_WAVEFORM  = 4'd5;
   localparam logic [3:0] REG_RAM_PTR   = 4'd6;
   localparam logic [3:0] REG_RAM_DATA  = 4'd7;
   localparam logic [3:0] REG_COMMIT    = 4'd8;

   localparam logic [3:0] BROADCAST = 4'd15;

   // Bit positions of the per-field write enables fed to each channel
   localparam int NUM_FIELDS    = 6;
   localparam int FLD_FREQUENCY = 0;
   localparam int FLD_PHASE     = 1;
   localparam int FLD_SKEW      = 2;
   localparam int FLD_AMPLITUDE = 3;
   localparam int FLD_OFFSET    = 4;
   localparam int FLD_WAVEFORM  = 5;

   localparam int RAM_DEPTH = 1024;
   localparam int RAM_AW    = 10;
   localparam int RAM_DW    = 16;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_COMMIT_WAIT = 2'd1,
      ST_SYNC        = 2'd2
   } state_t;

   function automatic logic is_reserved_reg(input logic [3:0] reg_idx);
      return reg_idx > REG_COMMIT;
   endfunction

endpackage

// File: rtl/dds_channel_regs.sv
// Shadow/live parameter pair for one DDS channel; live copies load from the
// shadows only on the commit strobe.
module dds_channel_regs
   import dds_ctrl_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_FIELDS-1:0] i_we,
   input  logic [23:0]           i_data,
   input  logic                  i_commit,
   output logic [23:0]           o_frequency,
   output logic [15:0]           o_phase,
   output logic [15:0]           o_skew,
   output logic [15:0]           o_amplitude,
   output logic [15:0]           o_offset,
   output logic                  o_waveform
);

   logic [23:0] r_sh_frequency, r_lv_frequency;
   logic [15:0] r_sh_phase,     r_lv_phase;
   logic [15:0] r_sh_skew,      r_lv_skew;
   logic [15:0] r_sh_amplitude, r_lv_amplitude;
   logic [15:0] r_sh_offset,    r_lv_offset;
   logic        r_sh_waveform,  r_lv_waveform;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sh_frequency <= '0;
         r_sh_phase     <= '0;
         r_sh_skew      <= '0;
         r_sh_amplitude <= '0;
         r_sh_offset    <= '0;
         r_sh_waveform  <= 1'b0;
         r_lv_frequency <= '0;
         r_lv_phase     <= '0;
         r_lv_skew      <= '0;
         r_lv_amplitude <= '0;
         r_lv_offset    <= '0;
         r_lv_waveform  <= 1'b0;
      end else begin
         if (i_we[FLD_FREQUENCY]) r_sh_frequency <= i_data;
         if (i_we[FLD_PHASE])     r_sh_phase     <= i_data[15:0];
         if (i_we[FLD_SKEW])      r_sh_skew      <= i_data[15:0];
         if (i_we[FLD_AMPLITUDE]) r_sh_amplitude <= i_data[15:0];
         if (i_we[FLD_OFFSET])    r_sh_offset    <= i_data[15:0];
         if (i_we[FLD_WAVEFORM])  r_sh_waveform  <= i_data[0];
         // A commit and a shadow write never share a cycle (one command per edge)
         if (i_commit) begin
            r_lv_frequency <= r_sh_frequency;
            r_lv_phase     <= r_sh_phase;
            r_lv_skew      <= r_sh_skew;
            r_lv_amplitude <= r_sh_amplitude;
            r_lv_offset    <= r_sh_offset;
            r_lv_waveform  <= r_sh_waveform;
         end
      end
   end

   assign o_frequency = r_lv_frequency;
   assign o_phase     = r_lv_phase;
   assign o_skew      = r_lv_skew;
   assign o_amplitude = r_lv_amplitude;
   assign o_offset    = r_lv_offset;
   assign o_waveform  = r_lv_waveform;

endmodule

// File: rtl/dds_bank_ctrl.sv
// Command sequencer for the DDS bank: decodes host commands, writes channel
// shadows and waveform RAM, and runs the commit / settle / Sync sequence.
module dds_bank_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int N          = 12,
   parameter int SYNC_DELAY = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic [3:0]        Cmd_Channel,
   input  logic [3:0]        Cmd_Register,
   input  logic [23:0]       Cmd_Data,
   output logic [24*N-1:0]   Frequency,
   output logic [16*N-1:0]   Phase,
   output logic [16*N-1:0]   Skew,
   output logic [16*N-1:0]   Amplitude,
   output logic [16*N-1:0]   Offset,
   output logic [N-1:0]      Waveform,
   output logic              Sync,
   output logic [RAM_DW-1:0] RAM_Data,
   output logic [RAM_AW-1:0] RAM_Address,
   output logic [N-1:0]      RAM_Write,
   output logic              Busy,
   output logic              Error,
   output state_t            Dbg_State
);

   // Handshake: a command transfers on a rising edge where Cmd_Valid and
   // Cmd_Ready are both high; Cmd_Ready is a register and never looks at
   // Cmd_Valid, and it is only high in IDLE.

   state_t                  r_state;
   logic [7:0]              r_cnt;
   logic                    r_cmd_ready;
   logic                    r_busy;
   logic                    r_sync;
   logic                    r_error;
   logic [RAM_AW-1:0]       r_ram_ptr;
   logic [RAM_AW-1:0]       r_ram_addr;
   logic [RAM_DW-1:0]       r_ram_data;
   logic [N-1:0]            r_ram_write;

   logic                    w_accept;
   logic                    w_bcast;
   logic                    w_ch_bad;
   logic                    w_is_commit;
   logic                    w_err;
   logic                    w_ok;
   logic                    w_commit;
   logic                    w_ram_wr;
   logic                    w_ptr_wr;
   logic [N-1:0]            w_ch_sel;
   logic [NUM_FIELDS-1:0]   w_field_we;

   assign w_accept    = Cmd_Valid && r_cmd_ready;
   assign w_bcast     = (Cmd_Channel == BROADCAST);
   assign w_ch_bad    = !w_bcast && (int'(Cmd_Channel) >= N);
   assign w_is_commit = (Cmd_Register == REG_COMMIT);
   // Commit applies to every channel, so its channel field cannot be invalid
   assign w_err       = w_accept && (is_reserved_reg(Cmd_Register) || (!w_is_commit && w_ch_bad));
   assign w_ok        = w_accept && !w_err;
   assign w_commit    = w_ok && w_is_commit;
   assign w_ram_wr    = w_ok && (Cmd_Register == REG_RAM_DATA);
   assign w_ptr_wr    = w_ok && (Cmd_Register == REG_RAM_PTR);

   always_comb begin
      w_field_we = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         w_field_we[f] = w_ok && (Cmd_Register == 4'(f));
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic [NUM_FIELDS-1:0] w_we;

      assign w_ch_sel[gi] = w_bcast || (Cmd_Channel == 4'(gi));
      assign w_we         = w_ch_sel[gi] ? w_field_we : '0;

      dds_channel_regs u_regs (
         .i_clk       (Clk),
         .i_rst       (Reset),
         .i_we        (w_we),
         .i_data      (Cmd_Data),
         .i_commit    (w_commit),
         .o_frequency (Frequency[24*gi +: 24]),
         .o_phase     (Phase[16*gi +: 16]),
         .o_skew      (Skew[16*gi +: 16]),
         .o_amplitude (Amplitude[16*gi +: 16]),
         .o_offset    (Offset[16*gi +: 16]),
         .o_waveform  (Waveform[gi])
      );
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_sync      <= 1'b0;
         r_error     <= 1'b0;
         r_ram_ptr   <= '0;
         r_ram_addr  <= '0;
         r_ram_data  <= '0;
         r_ram_write <= '0;
      end else begin
         r_sync      <= 1'b0;
         r_error     <= w_err;
         r_ram_write <= '0;

         // The pointer wraps 1023 -> 0 through natural 10-bit overflow
         if (w_ram_wr) begin
            r_ram_addr  <= r_ram_ptr;
            r_ram_data  <= Cmd_Data[RAM_DW-1:0];
            r_ram_write <= w_ch_sel;
            r_ram_ptr   <= r_ram_ptr + RAM_AW'(1);
         end else if (w_ptr_wr) begin
            r_ram_ptr   <= Cmd_Data[RAM_AW-1:0];
         end

         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_commit) begin
                  r_state     <= ST_COMMIT_WAIT;
                  r_cnt       <= 8'(SYNC_DELAY);
                  r_busy      <= 1'b1;
                  r_cmd_ready <= 1'b0;
               end
            end
            ST_COMMIT_WAIT: begin
               if (r_cnt == 8'd1) begin
                  r_state <= ST_SYNC;
                  r_sync  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_SYNC: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign Cmd_Ready   = r_cmd_ready;
   assign Busy        = r_busy;
   assign Sync        = r_sync;
   assign Error       = r_error;
   assign RAM_Address = r_ram_addr;
   assign RAM_Data    = r_ram_data;
   assign RAM_Write   = r_ram_write;
   assign Dbg_State   = r_state;

endmodule

// File: tb/tb_dds_bank_ctrl.sv
// Directed bench for dds_bank_ctrl: a driver issues commands, pushes the
// hand-computed Sync/Error/RAM events into exp_q, and a monitor pops them.
module tb_dds_bank_ctrl;
   import dds_ctrl_pkg::*;

   localparam int N  = 12;
   localparam int D  = 8;
   localparam int EW = 56;
   localparam logic [1:0] K_RAM  = 2'd1;
   localparam logic [1:0] K_SYNC = 2'd2;
   localparam logic [1:0] K_ERR  = 2'd3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              Cmd_Valid = 1'b0;
   logic              Cmd_Ready;
   logic [3:0]        Cmd_Channel = '0;
   logic [3:0]        Cmd_Register = '0;
   logic [23:0]       Cmd_Data = '0;
   logic [24*N-1:0]   Frequency;
   logic [16*N-1:0]   Phase, Skew, Amplitude, Offset;
   logic [N-1:0]      Waveform;
   logic              Sync;
   logic [RAM_DW-1:0] RAM_Data;
   logic [RAM_AW-1:0] RAM_Address;
   logic [N-1:0]      RAM_Write;
   logic              Busy, Error;
   state_t            dbg_state;

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];

   dds_bank_ctrl #(.N(N), .SYNC_DELAY(D)) dut (
      .Clk          (clk),
      .Reset        (rst),
      .Cmd_Valid    (Cmd_Valid),
      .Cmd_Ready    (Cmd_Ready),
      .Cmd_Channel  (Cmd_Channel),
      .Cmd_Register (Cmd_Register),
      .Cmd_Data     (Cmd_Data),
      .Frequency    (Frequency),
      .Phase        (Phase),
      .Skew         (Skew),
      .Amplitude    (Amplitude),
      .Offset       (Offset),
      .Waveform     (Waveform),
      .Sync         (Sync),
      .RAM_Data     (RAM_Data),
      .RAM_Address  (RAM_Address),
      .RAM_Write    (RAM_Write),
      .Busy         (Busy),
      .Error        (Error),
      .Dbg_State    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic expect_ev(input logic [1:0] kind, input int at, input logic [37:0] pay);
      exp_q.push_back({kind, 16'(at), pay});
   endtask

   task automatic pop_check(input string name, input logic [1:0] kind, input logic [37:0] pay);
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      act = {kind, cyc[15:0], pay};
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: unexpected event %0h, expected none", name, act);
      end else begin
         e = exp_q.pop_front();
         check(name, 64'(act), 64'(e));
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (RAM_Write != '0) pop_check("ram_write", K_RAM, {RAM_Address, RAM_Data, RAM_Write});
      if (Sync)            pop_check("sync", K_SYNC, '0);
      if (Error)           pop_check("error", K_ERR, '0);
   end

   // driver tasks: every task returns 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] ch, input logic [3:0] rg, input logic [23:0] data,
                       output int acc);
      int g;
      g = 0;
      Cmd_Channel  = ch;
      Cmd_Register = rg;
      Cmd_Data     = data;
      Cmd_Valid    = 1'b1;
      while (!Cmd_Ready && g < 100) begin
         tick(1);
         g++;
      end
      if (!Cmd_Ready) begin
         n_checks++;
         $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", Cmd_Ready, g);
      end
      @(posedge clk);
      #1;
      acc       = cyc;
      Cmd_Valid = 1'b0;
   endtask

   task automatic wait_ready(output int at);
      int g;
      g = 0;
      tick(1);
      while (!Cmd_Ready && g < 300) begin
         tick(1);
         g++;
      end
      if (!Cmd_Ready) begin
         n_checks++;
         $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", Cmd_Ready, g);
      end
      at = cyc;
   endtask

   initial begin
      int a, b, c, r;

      // reset state
      tick(3);
      check("rst_ready", Cmd_Ready, 0);
      check("rst_live", {|Frequency, |Phase, |Skew, |Amplitude, |Offset, |Waveform}, 0);
      check("rst_ram", {RAM_Address, RAM_Data, RAM_Write}, 0);
      check("rst_flags", {Sync, Error, Busy}, 0);
      rst = 1'b0;
      check("ready_before_edge", Cmd_Ready, 0);
      tick(1);
      check("ready_after_release", Cmd_Ready, 1);

      // shadow write then commit
      send(4'd3, REG_AMPLITUDE, 24'hFF1234, a);
      check("shadow_no_live", Amplitude[63:48], 16'h0000);
      tick(2);
      check("shadow_still_no_live", Amplitude[63:48], 16'h0000);
      send(4'd0, REG_COMMIT, 24'h0, a);
      expect_ev(K_SYNC, a + D, '0);
      check("commit_amp", Amplitude[63:48], 16'h1234);
      check("commit_amp_ch2", Amplitude[47:32], 16'h0000);
      check("commit_busy", Busy, 1);
      check("commit_ready_low", Cmd_Ready, 0);
      check("commit_state", dbg_state, ST_COMMIT_WAIT);
      wait_ready(r);
      check("ready_return_cyc", r, a + D + 1);
      check("busy_clear", Busy, 0);

      // RAM pointer wrap and back-to-back writes
      send(4'd0, REG_RAM_PTR, 24'h00FFFE, a);
      send(4'd0, REG_RAM_DATA, 24'h00AAAA, a);
      expect_ev(K_RAM, a, {10'd1022, 16'hAAAA, 12'h001});
      send(4'd0, REG_RAM_DATA, 24'h00BBBB, b);
      expect_ev(K_RAM, b, {10'd1023, 16'hBBBB, 12'h001});
      send(4'd0, REG_RAM_DATA, 24'h00CCCC, c);
      expect_ev(K_RAM, c, {10'd0, 16'hCCCC, 12'h001});
      check("ram_b2b_span", c - a, 2);
      send(BROADCAST, REG_RAM_DATA, 24'h125555, a);
      expect_ev(K_RAM, a, {10'd1, 16'h5555, 12'hFFF});
      send(4'd11, REG_RAM_DATA, 24'h000F0F, a);
      expect_ev(K_RAM, a, {10'd2, 16'h0F0F, 12'h800});

      // broadcast most-negative frequency
      send(BROADCAST, REG_FREQUENCY, 24'h800000, a);
      check("bcast_shadow_only", Frequency[287:264], 24'h0);
      send(4'd0, REG_COMMIT, 24'h0, a);
      expect_ev(K_SYNC, a + D, '0);
      for (int i = 0; i < N; i++) check("bcast_freq", Frequency[24*i +: 24], 24'h800000);
      check("amp_kept", Amplitude[63:48], 16'h1234);
      wait_ready(r);

      // invalid channel / reserved register
      send(4'd13, REG_PHASE, 24'h001111, a);
      expect_ev(K_ERR, a, '0);
      check("err_ready_ch13", Cmd_Ready, 1);
      send(4'd2, 4'd11, 24'h002222, a);
      expect_ev(K_ERR, a, '0);
      check("err_ready_reg11", Cmd_Ready, 1);
      send(4'd14, REG_PHASE, 24'h003333, a);
      expect_ev(K_ERR, a, '0);
      tick(1);
      check("err_no_busy", Busy, 0);
      check("err_freq_kept", Frequency[23:0], 24'h800000);
      send(4'd0, REG_COMMIT, 24'h0, a);
      expect_ev(K_SYNC, a + D, '0);
      check("err_no_phase", |Phase, 0);
      wait_ready(r);

      // reset in the middle of COMMIT_WAIT
      send(4'd1, REG_FREQUENCY, 24'h123456, a);
      send(4'd0, REG_COMMIT, 24'h0, a);
      check("abort_live_before", Frequency[47:24], 24'h123456);
      tick(3);
      rst = 1'b1;
      #1;
      check("abort_live", {|Frequency, |Phase, |Skew, |Amplitude, |Offset, |Waveform}, 0);
      check("abort_flags", {Sync, Busy, Cmd_Ready}, 0);
      check("abort_state", dbg_state, ST_IDLE);
      tick(2);
      rst = 1'b0;
      tick(D + 4);
      check("abort_ready", Cmd_Ready, 1);
      send(4'd0, REG_RAM_DATA, 24'h007777, a);
      expect_ev(K_RAM, a, {10'd0, 16'h7777, 12'h001});

      // Cmd_Valid held through a commit
      send(4'd0, REG_COMMIT, 24'h0, a);
      expect_ev(K_SYNC, a + D, '0);
      send(4'd5, REG_PHASE, 24'h004321, b);
      check("held_accept_cyc", b, a + D + 2);
      check("phase_pending", Phase[95:80], 16'h0000);
      send(4'd0, REG_COMMIT, 24'h0, c);
      expect_ev(K_SYNC, c + D, '0);
      check("phase_committed", Phase[95:80], 16'h4321);
      wait_ready(r);

      // report
      tick(3);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
